// File: rtl/ahb_pkg.sv
// AHB-Lite encodings and the copy master's state type.
// Constants only; no logic.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_D = 3'd2,
    ST_WR_A = 3'd3,
    ST_WR_D = 3'd4,
    ST_FIN  = 3'd5,
    ST_ERR  = 3'd6
  } copy_state_e;

endpackage

// File: rtl/ahblite_copy_master.sv
// Single-channel AHB-Lite word copy master: one non-pipelined read then write per word,
// 4 cycles/word at zero wait, slave waits stall via HREADY; cmd accepted only in IDLE.
module ahblite_copy_master
  import ahb_pkg::*;
#(
  parameter int         LEN_WIDTH = 16,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [31:0]          cmd_src,
  input  logic [31:0]          cmd_dst,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [31:0]          HADDR,
  output logic [1:0]           HTRANS,
  output logic [2:0]           HSIZE,
  output logic [2:0]           HBURST,
  output logic [3:0]           HPROT,
  output logic                 HMASTLOCK,
  output logic                 HWRITE,
  output logic [31:0]          HWDATA,
  input  logic                 HREADY,
  input  logic [31:0]          HRDATA,
  input  logic [1:0]           HRESP
);

  copy_state_e          state_q, state_d;
  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [31:0]          buf_q, buf_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          haddr_q, haddr_d;
  logic [31:0]          hwdata_q, hwdata_d;
  logic [1:0]           htrans_q, htrans_d;
  logic                 hwrite_q, hwrite_d;
  logic                 resp_err;
  logic [3:0]           unused_addr_lsbs;

  // Byte-offset bits are dropped: every transfer is word aligned.
  assign unused_addr_lsbs = {cmd_src[1:0], cmd_dst[1:0]};
  assign resp_err         = (HRESP & HRESP_ERROR) != HRESP_OKAY;

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    htrans_d = htrans_q;
    hwrite_d = hwrite_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          src_d = {cmd_src[31:2], 2'b00};
          dst_d = {cmd_dst[31:2], 2'b00};
          cnt_d = cmd_len;
          if (cmd_len == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d  = ST_RD_A;
            htrans_d = HTRANS_NONSEQ;
            haddr_d  = {cmd_src[31:2], 2'b00};
            hwrite_d = 1'b0;
          end
        end
      end
      ST_RD_A: begin
        if (HREADY) begin
          state_d  = ST_RD_D;
          htrans_d = HTRANS_IDLE;
        end
      end
      ST_RD_D: begin
        // The leading HREADY=0 cycle of a two-cycle ERROR is ignored here.
        if (HREADY) begin
          if (resp_err) begin
            state_d = ST_ERR;
          end else begin
            buf_d    = HRDATA;
            state_d  = ST_WR_A;
            htrans_d = HTRANS_NONSEQ;
            haddr_d  = dst_q;
            hwrite_d = 1'b1;
          end
        end
      end
      ST_WR_A: begin
        if (HREADY) begin
          state_d  = ST_WR_D;
          htrans_d = HTRANS_IDLE;
          hwdata_d = buf_q;
        end
      end
      ST_WR_D: begin
        if (HREADY) begin
          if (resp_err) begin
            state_d = ST_ERR;
          end else begin
            src_d = src_q + 32'd4;
            dst_d = dst_q + 32'd4;
            cnt_d = cnt_q - LEN_WIDTH'(1);
            if (cnt_q == LEN_WIDTH'(1)) begin
              state_d = ST_FIN;
            end else begin
              state_d  = ST_RD_A;
              htrans_d = HTRANS_NONSEQ;
              haddr_d  = src_q + 32'd4;
              hwrite_d = 1'b0;
            end
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: begin
        state_d  = ST_IDLE;
        htrans_d = HTRANS_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      buf_q    <= '0;
      cnt_q    <= '0;
      haddr_q  <= '0;
      hwdata_q <= '0;
      htrans_q <= HTRANS_IDLE;
      hwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
    end
  end

  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HWDATA    = hwdata_q;
  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FIN);
  assign error     = (state_q == ST_ERR);

endmodule

// File: tb/tb_ahblite_copy_master.sv
// Bench for ahblite_copy_master: block-RAM slave model with wait/error injection,
// directed vector table, reset-mid-copy sequence and randomized commands vs a word-level copy model.
module tb_ahblite_copy_master;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_src, cmd_dst;
  logic [15:0] cmd_len;
  logic        busy, done, error;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK, HWRITE, HREADY;

  ahblite_copy_master #(.LEN_WIDTH(16), .HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .cmd_len(cmd_len), .busy(busy), .done(done), .error(error),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HMASTLOCK(HMASTLOCK), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    bit [31:0] addr;
    bit        wr;
    bit [31:0] data;
    bit        err;
  } xfer_t;

  typedef struct {
    bit [31:0] src;
    bit [31:0] dst;
    int        len;
    int        waits;
    bit        err_en;
    bit [31:0] err_addr;
    int        exp_lat;
    bit        exp_err;
    int        exp_nonseq;
    int        chk_idx;
    bit [31:0] chk_addr;
  } vec_t;

  xfer_t     log_q[$];
  xfer_t     exp_q[$];
  bit [31:0] mem[bit [31:0]];
  bit [31:0] ref_mem[bit [31:0]];
  vec_t      tbl[6];

  int n_vec = 0, n_mis = 0, proto_err = 0, nonseq_cnt = 0;
  int cfg_waits = 0, cfg_stall = 0;
  bit cfg_rand = 0, cfg_err_en = 0;
  bit [31:0] cfg_err_addr = 0;

  // slave data-phase tracking
  bit        dp_active = 0, dp_write = 0, dp_err = 0, dp_err_stage = 0;
  bit [31:0] dp_addr = 0;
  int        dp_wait = 0;
  bit        prev_hold = 0, prev_write = 0;
  bit [1:0]  prev_trans = 0;
  bit [31:0] prev_addr = 0, prev_wdata = 0;

  function automatic bit [31:0] mem_rd(input bit [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic bit [31:0] ref_rd(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic slave_cycle();
    bit        hr;
    bit [1:0]  rsp;
    bit [31:0] rd;
    if (HSIZE !== 3'b010 || HBURST !== 3'b000 || HPROT !== 4'b0011 || HMASTLOCK !== 1'b0 ||
        HADDR[1:0] !== 2'b00) proto_err++;
    if (HTRANS !== 2'b00 && HTRANS !== 2'b10) proto_err++;
    if (dp_active && HTRANS !== 2'b00) proto_err++;
    if (prev_hold && (HADDR !== prev_addr || HWRITE !== prev_write || HWDATA !== prev_wdata ||
        (prev_trans == 2'b10 && HTRANS !== 2'b10))) proto_err++;
    hr = 1'b1; rsp = 2'b00; rd = $urandom;
    if (dp_active) begin
      if (dp_err) begin
        if (!dp_err_stage) begin hr = 1'b0; rsp = 2'b01; dp_err_stage = 1'b1; end
        else begin hr = 1'b1; rsp = 2'b01; end
      end else if (dp_wait > 0) begin
        hr = 1'b0; dp_wait--;
      end else if (!dp_write) begin
        rd = mem_rd(dp_addr);
      end
    end else if (cfg_stall > 0 && $urandom_range(0, 99) < cfg_stall) begin
      hr = 1'b0;
    end
    HREADY = hr; HRESP = rsp; HRDATA = rd;
    if (hr) begin
      if (dp_active) begin
        log_q.push_back('{dp_addr, dp_write, dp_write ? HWDATA : rd, dp_err});
        if (dp_write && !dp_err) mem[dp_addr] = HWDATA;
        dp_active = 1'b0;
      end
      if (HTRANS == 2'b10) begin
        dp_active = 1'b1; dp_addr = HADDR; dp_write = HWRITE; dp_err_stage = 1'b0;
        dp_err = !HWRITE && cfg_err_en && (HADDR == cfg_err_addr);
        dp_wait = cfg_rand ? $urandom_range(0, 3) : cfg_waits;
        nonseq_cnt++;
      end
    end
    prev_hold = !hr && (HTRANS == 2'b10 || dp_active);
    prev_trans = HTRANS; prev_addr = HADDR; prev_write = HWRITE; prev_wdata = HWDATA;
  endtask

  initial begin
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        dp_active = 1'b0; prev_hold = 1'b0; HREADY = 1'b1; HRESP = 2'b00;
      end else begin
        slave_cycle();
      end
    end
  end

  // Word-level copy: each word is read from the running memory image then written.
  task automatic model_copy(input bit [31:0] src, input bit [31:0] dst, input int len,
                            input bit err_en, input bit [31:0] err_addr, output bit exp_err);
    bit [31:0] s, d, v;
    exp_q.delete();
    exp_err = 1'b0;
    s = src & ~32'h3;
    d = dst & ~32'h3;
    for (int i = 0; i < len; i++) begin
      if (err_en && s == err_addr) begin
        exp_q.push_back('{s, 1'b0, 32'h0, 1'b1});
        exp_err = 1'b1;
        break;
      end
      v = ref_rd(s);
      exp_q.push_back('{s, 1'b0, v, 1'b0});
      exp_q.push_back('{d, 1'b1, v, 1'b0});
      ref_mem[d] = v;
      s += 32'd4;
      d += 32'd4;
    end
  endtask

  task automatic preload(input bit [31:0] src, input int n, input bit rnd);
    bit [31:0] a, v;
    for (int i = 0; i < n; i++) begin
      a = (src & ~32'h3) + 32'(4 * i);
      v = rnd ? $urandom : 32'h11111111 * 32'(i + 1);
      mem[a] = v;
      ref_mem[a] = v;
    end
  endtask

  task automatic run_cmd(input bit [31:0] src, input bit [31:0] dst, input int len,
                         input bit garbage, output int lat, output bit got_err);
    bit seen;
    @(negedge HCLK);
    check("ready_before_cmd", cmd_ready, 1);
    cmd_src = src; cmd_dst = dst; cmd_len = 16'(len); cmd_valid = 1'b1;
    @(posedge HCLK);
    lat = 0; seen = 1'b0; got_err = 1'b0;
    while (!seen && lat < 3000) begin
      @(negedge HCLK);
      lat++;
      if (garbage) begin
        cmd_valid = 1'($urandom_range(0, 1)); cmd_src = $urandom; cmd_dst = $urandom;
        cmd_len = 16'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      if (done || error) begin
        seen = 1'b1;
        got_err = error;
        check("busy_during_pulse", busy, 1);
        check("done_xor_error", done ^ error, 1);
      end
    end
    cmd_valid = 1'b0;
    if (!seen) begin
      n_vec++; n_mis++;
      $display("FAIL cmd_timeout: got no done/error, expected one within 3000 cycles");
    end else begin
      @(negedge HCLK);
      check("idle_after_pulse {done,error,busy,cmd_ready}", {done, error, busy, cmd_ready}, 4'b0001);
    end
  endtask

  task automatic do_vec(input bit [31:0] src, input bit [31:0] dst, input int len,
                        input int waits, input bit rnd, input bit err_en, input bit [31:0] err_addr,
                        input bit garbage, output int lat, output bit got_err);
    bit exp_err;
    int bad, diffs;
    cfg_waits = waits; cfg_rand = rnd; cfg_stall = rnd ? 20 : 0;
    cfg_err_en = err_en; cfg_err_addr = err_addr;
    log_q.delete();
    nonseq_cnt = 0;
    model_copy(src, dst, len, err_en, err_addr, exp_err);
    run_cmd(src, dst, len, garbage, lat, got_err);
    check("error_vs_model", got_err, exp_err);
    check("xfer_count", log_q.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      if (log_q[i].addr != exp_q[i].addr || log_q[i].wr != exp_q[i].wr || log_q[i].err != exp_q[i].err ||
          (!exp_q[i].err && log_q[i].data != exp_q[i].data)) begin
        if (bad == 0)
          $display("  first transfer difference at %0d: addr %h/%h wr %0d/%0d data %h/%h", i,
                   log_q[i].addr, exp_q[i].addr, log_q[i].wr, exp_q[i].wr, log_q[i].data, exp_q[i].data);
        bad++;
      end
    end
    check("xfer_content_diffs", bad, 0);
    diffs = 0;
    foreach (mem[k]) if (mem[k] != ref_rd(k)) diffs++;
    foreach (ref_mem[k]) if (!mem.exists(k) && ref_mem[k] != 0) diffs++;
    check("mem_image_diffs", diffs, 0);
    check("protocol_violations", proto_err, 0);
  endtask

  initial begin
    #900000;
    n_mis++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  gerr, found;
    HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'h0;
    cmd_valid = 1'b0; cmd_src = 32'h0; cmd_dst = 32'h0; cmd_len = 16'h0;

    //          src           dst           len wt err errad         lat eerr nseq idx chk_addr
    tbl[0] = '{32'h0000_0100, 32'h0000_0200, 4, 0, 0, 32'h0,         17, 0,   8,   7, 32'h0000_020C};
    tbl[1] = '{32'h0000_0100, 32'h0000_0200, 2, 2, 0, 32'h0,         17, 0,   4,   3, 32'h0000_0204};
    tbl[2] = '{32'h0000_0100, 32'h0000_0200, 3, 0, 1, 32'h0000_0104,  8, 1,   3,   1, 32'h0000_0200};
    tbl[3] = '{32'h0000_0100, 32'h0000_0200, 0, 0, 0, 32'h0,          1, 0,   0,  -1, 32'h0};
    tbl[4] = '{32'h0000_0103, 32'h0000_0200, 1, 0, 0, 32'h0,          5, 0,   2,   0, 32'h0000_0100};
    tbl[5] = '{32'hFFFF_FFFC, 32'h0000_0200, 2, 0, 0, 32'h0,          9, 0,   4,   2, 32'h0000_0000};

    #12;
    check("rst_htrans", HTRANS, 2'b00);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwrite", HWRITE, 0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_flags {busy,done,error,cmd_ready}", {busy, done, error, cmd_ready}, 4'b0001);
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);

    for (int v = 0; v < 6; v++) begin
      preload(tbl[v].src, tbl[v].len + 1, 1'b0);
      do_vec(tbl[v].src, tbl[v].dst, tbl[v].len, tbl[v].waits, 1'b0, tbl[v].err_en,
             tbl[v].err_addr, 1'b0, lat, gerr);
      check($sformatf("vec%0d_latency", v), lat, tbl[v].exp_lat);
      check($sformatf("vec%0d_error", v), gerr, tbl[v].exp_err);
      check($sformatf("vec%0d_nonseq_count", v), nonseq_cnt, tbl[v].exp_nonseq);
      if (tbl[v].chk_idx >= 0) begin
        if (tbl[v].chk_idx < log_q.size())
          check($sformatf("vec%0d_xfer%0d_addr", v, tbl[v].chk_idx), log_q[tbl[v].chk_idx].addr, tbl[v].chk_addr);
        else begin
          n_vec++; n_mis++;
          $display("FAIL vec%0d_xfer%0d_addr: got only %0d transfers, expected addr 0x%08h",
                   v, tbl[v].chk_idx, log_q.size(), tbl[v].chk_addr);
        end
      end
      if (v == 0) check("vec0_dst_word3", mem_rd(32'h0000_020C), 32'h4444_4444);
    end

    // Reset asserted while the first write address phase is on the bus.
    cfg_waits = 0; cfg_rand = 0; cfg_stall = 0; cfg_err_en = 0;
    preload(32'h300, 4, 1'b1);
    @(negedge HCLK);
    cmd_src = 32'h300; cmd_dst = 32'h400; cmd_len = 16'd4; cmd_valid = 1'b1;
    @(posedge HCLK);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (HTRANS == 2'b10 && HWRITE) found = 1'b1;
      else @(negedge HCLK);
    end
    check("rst_test_reached_wr_a", found, 1);
    #2 HRESETn = 1'b0;
    #1;
    check("async_rst_htrans", HTRANS, 2'b00);
    check("async_rst_busy", busy, 0);
    check("async_rst_cmd_ready", cmd_ready, 1);
    repeat (2) @(negedge HCLK);
    check("rst_held_htrans", HTRANS, 2'b00);
    #1 HRESETn = 1'b1;
    ref_mem = mem;
    do_vec(32'h300, 32'h400, 3, 0, 1'b0, 1'b0, 32'h0, 1'b0, lat, gerr);
    check("post_rst_latency", lat, 13);
    check("post_rst_error", gerr, 0);

    // Randomized commands, overlapping regions, waits, stalls, errors, noise on cmd_* while busy.
    for (int r = 0; r < 40; r++) begin
      bit [31:0] s, d, ea;
      int        len;
      bit        een;
      s   = 32'h1000 + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
      d   = 32'h1000 + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
      len = $urandom_range(0, 10);
      een = (len > 0) && ($urandom_range(0, 3) == 0);
      ea  = (s & ~32'h3) + 32'(4 * $urandom_range(0, (len > 0) ? len - 1 : 0));
      preload(s, len, 1'b1);
      do_vec(s, d, len, 0, 1'b1, een, ea, 1'($urandom_range(0, 1)), lat, gerr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
